// File: rtl/fetch_pkg.sv
// fetch_pkg: types and defaults shared by the PC stage, fetch queue and decode
package fetch_pkg;

    localparam int IW = 9;
    localparam int PW = 16;
    localparam logic [IW-1:0] HALT_OP = 9'h1FF;

    typedef struct packed {
        logic [PW-1:0] pc;
        logic [IW-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: first-word fall-through queue between fetch and decode with flush and halt detect
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IW = fetch_pkg::IW,
    parameter int PW = fetch_pkg::PW,
    parameter logic [IW-1:0] HALT_OP = fetch_pkg::HALT_OP,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          Init_n,
    input  logic          Fetch_valid,
    input  logic [PW-1:0] Fetch_PC,
    input  logic [IW-1:0] Fetch_instr,
    output logic          Fetch_ready,
    input  logic          Flush,
    output logic          Dec_valid,
    output logic [PW-1:0] Dec_PC,
    output logic [IW-1:0] Dec_instr,
    input  logic          Dec_ready,
    output logic [CW-1:0] Count,
    output logic          Empty,
    output logic          Full,
    output logic          Done
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign Empty       = Count == '0;
    assign Full        = Count == CW'(DEPTH);
    assign Fetch_ready = !Full;
    assign Dec_valid   = !Empty;
    assign push        = Fetch_valid & Fetch_ready;
    assign pop         = Dec_valid & Dec_ready;
    assign Dec_PC      = mem[rd_ptr].pc;
    assign Dec_instr   = mem[rd_ptr].instr;

    // storage write; the array is left unreset and a flushed push is simply never made visible
    always_ff @(posedge CLK) begin
        if (push && !Flush)
            mem[wr_ptr] <= '{pc: Fetch_PC, instr: Fetch_instr};
    end

    // pointers, occupancy and sticky halt flag; flush overrides push and pop
    always_ff @(posedge CLK or negedge Init_n) begin
        if (!Init_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            Count  <= '0;
            Done   <= 1'b0;
        end else if (Flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            Count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            Count  <= (push && !pop) ? Count + 1'b1 : (pop && !push) ? Count - 1'b1 : Count;
            Done   <= Done | (pop && Dec_instr == HALT_OP);
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed scoreboard bench for instr_fetch_queue
module tb_instr_fetch_queue;
    import fetch_pkg::*;

    logic        CLK = 1'b0;
    logic        Init_n = 1'b0;
    logic        Fetch_valid = 1'b0;
    logic [15:0] Fetch_PC = '0;
    logic [8:0]  Fetch_instr = '0;
    logic        Fetch_ready;
    logic        Flush = 1'b0;
    logic        Dec_valid;
    logic [15:0] Dec_PC;
    logic [8:0]  Dec_instr;
    logic        Dec_ready = 1'b0;
    logic [2:0]  Count;
    logic        Empty;
    logic        Full;
    logic        Done;

    fetch_entry_t q[$];
    logic         done_m = 1'b0;
    int           checks = 0;
    int           errors = 0;

    instr_fetch_queue dut (
        .CLK(CLK), .Init_n(Init_n), .Fetch_valid(Fetch_valid), .Fetch_PC(Fetch_PC),
        .Fetch_instr(Fetch_instr), .Fetch_ready(Fetch_ready), .Flush(Flush),
        .Dec_valid(Dec_valid), .Dec_PC(Dec_PC), .Dec_instr(Dec_instr), .Dec_ready(Dec_ready),
        .Count(Count), .Empty(Empty), .Full(Full), .Done(Done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic state_chk(input string tag);
        chk({tag, "_count"}, 32'(Count), 32'(q.size()));
        chk({tag, "_empty"}, 32'(Empty), 32'(q.size() == 0));
        chk({tag, "_full"}, 32'(Full), 32'(q.size() == 4));
        chk({tag, "_fready"}, 32'(Fetch_ready), 32'(q.size() != 4));
        chk({tag, "_dvalid"}, 32'(Dec_valid), 32'(q.size() != 0));
        chk({tag, "_done"}, 32'(Done), 32'(done_m));
        if (q.size() != 0) begin
            chk({tag, "_head_pc"}, 32'(Dec_PC), 32'(q[0].pc));
            chk({tag, "_head_instr"}, 32'(Dec_instr), 32'(q[0].instr));
        end
    endtask

    task automatic step(input string tag, input logic fv, input logic [15:0] pc,
                        input logic [8:0] ins, input logic dr, input logic fl);
        bit push, pop;
        Fetch_valid = fv;
        Fetch_PC = pc;
        Fetch_instr = ins;
        Dec_ready = dr;
        Flush = fl;
        push = fv && q.size() < 4;
        pop = dr && q.size() > 0;
        #1;
        if (pop) begin
            chk({tag, "_pop_pc"}, 32'(Dec_PC), 32'(q[0].pc));
            chk({tag, "_pop_instr"}, 32'(Dec_instr), 32'(q[0].instr));
        end
        @(posedge CLK);
        #1;
        if (fl) q.delete();
        else begin
            if (pop) begin
                if (q[0].instr == 9'h1FF) done_m = 1'b1;
                void'(q.pop_front());
            end
            if (push) q.push_back('{pc: pc, instr: ins});
        end
        Fetch_valid = 1'b0;
        Dec_ready = 1'b0;
        Flush = 1'b0;
        state_chk(tag);
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        state_chk("in_reset");
        Init_n = 1'b1;
        #1;
        state_chk("post_reset");

        for (int i = 0; i < 4; i++) step("fill", 1'b1, 16'(i), 9'h010 + 9'(i), 1'b0, 1'b0);
        chk("full_flag", 32'(Full), 32'd1);
        chk("full_head_pc", 32'(Dec_PC), 32'd0);
        step("push_full", 1'b1, 16'd4, 9'h014, 1'b0, 1'b0);
        chk("full_count_held", 32'(Count), 32'd4);

        step("pop_a", 1'b0, 16'd0, 9'h0, 1'b1, 1'b0);
        step("pop_b", 1'b0, 16'd0, 9'h0, 1'b1, 1'b0);
        chk("wrap_head", 32'(Dec_PC), 32'd2);
        for (int i = 4; i < 12; i++) step("stream", 1'b1, 16'(i), 9'h010 + 9'(i), 1'b1, 1'b0);
        while (q.size() != 0) step("drain1", 1'b0, 16'd0, 9'h0, 1'b1, 1'b0);

        for (int i = 0; i < 3; i++) step("pre_flush", 1'b1, 16'(30 + i), 9'h030 + 9'(i), 1'b0, 1'b0);
        step("flush", 1'b1, 16'd20, 9'h020, 1'b1, 1'b1);
        chk("flush_count", 32'(Count), 32'd0);
        step("post_flush", 1'b1, 16'd21, 9'h021, 1'b0, 1'b0);
        chk("post_flush_head", 32'(Dec_PC), 32'd21);
        step("drain2", 1'b0, 16'd0, 9'h0, 1'b1, 1'b0);

        step("halt_push", 1'b1, 16'd7, 9'h1FF, 1'b0, 1'b0);
        chk("done_before_pop", 32'(Done), 32'd0);
        step("halt_pop", 1'b0, 16'd0, 9'h0, 1'b1, 1'b0);
        chk("done_set", 32'(Done), 32'd1);
        step("halt_push2", 1'b1, 16'd8, 9'h1FF, 1'b0, 1'b0);
        step("halt_flush", 1'b0, 16'd0, 9'h0, 1'b1, 1'b1);
        chk("done_after_flush", 32'(Done), 32'd1);

        for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 16'(40 + i), 9'h040 + 9'(i), 1'b0, 1'b0);
        Fetch_valid = 1'b1;
        Fetch_PC = 16'd50;
        Fetch_instr = 9'h050;
        #3;
        Init_n = 1'b0;
        #1;
        chk("async_count", 32'(Count), 32'd0);
        chk("async_dvalid", 32'(Dec_valid), 32'd0);
        chk("async_done", 32'(Done), 32'd0);
        q.delete();
        done_m = 1'b0;
        @(posedge CLK);
        #1;
        Fetch_valid = 1'b0;
        Init_n = 1'b1;
        state_chk("after_async");
        step("after_async_push", 1'b1, 16'd60, 9'h060, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
